// File: rtl/display_arbiter_if.sv
// Source-side requests and driver-side outputs of the display arbiter.
interface display_arbiter_if #(
   parameter int NUM_SRC = 3
);
   logic [NUM_SRC-1:0]    req;
   logic [32*NUM_SRC-1:0] in_value;
   logic [NUM_SRC-1:0]    in_hex;
   logic [NUM_SRC-1:0]    in_error;
   logic [31:0]           value;
   logic                  show_in_hex;
   logic                  error;
   logic                  blank;
   logic [2:0]            owner;
   logic                  owner_valid;
   logic [NUM_SRC-1:0]    grant;

   modport master (
      output req, in_value, in_hex, in_error,
      input  value, show_in_hex, error, blank,
      input  owner, owner_valid, grant
   );

   modport slave (
      input  req, in_value, in_hex, in_error,
      output value, show_in_hex, error, blank,
      output owner, owner_valid, grant
   );
endinterface

// File: rtl/display_arbiter.sv
// Shares one multiplexed display among NUM_SRC sources with settle/hold timing.
// Optional DISPLAY_ARBITER_ROUND_ROBIN_EN: round-robin non-error arbitration.
module display_arbiter #(
   parameter int NUM_SRC       = 3,
   parameter int SETTLE_CYCLES = 256,
   parameter int HOLD_CYCLES   = 25000000
) (
   input logic              clock,
   input logic              reset_n,
   display_arbiter_if.slave bus
);
   localparam int MAXC = (SETTLE_CYCLES > HOLD_CYCLES) ?
                         SETTLE_CYCLES : HOLD_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD, OPEN} state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [2:0]         owner;
   logic               valid;
   logic [NUM_SRC-1:0] grant;
   logic [31:0]        value;
   logic               hex;
   logic               err;
   logic               blank;

   logic               owner_req;
   logic               owner_err;
   logic               err_hit;
   logic [2:0]         err_idx;
   logic               req_any;
   logic [2:0]         win_idx;
   logic               take;
   logic [2:0]         take_idx;
   logic [2:0]         sel_idx;
   logic               sel_req;
   logic [31:0]        sel_value;
   logic               sel_hex;
   logic               sel_err;
   logic [NUM_SRC-1:0] grant_nxt;

`ifdef DISPLAY_ARBITER_ROUND_ROBIN_EN
   logic [2:0]         rr_start;
`endif

   always_comb begin
      owner_req = 1'b0;
      owner_err = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (valid && 3'(i) == owner) begin
            owner_req = bus.req[i];
            owner_err = bus.req[i] & bus.in_error[i];
         end

      // An error owner yields only to a lower-index error source.
      err_hit = 1'b0;
      err_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (bus.req[i] && bus.in_error[i] &&
             !(valid && 3'(i) == owner) &&
             (!owner_err || 3'(i) < owner)) begin
            err_hit = 1'b1;
            err_idx = 3'(i);
         end

      req_any = |bus.req;
      win_idx = '0;
`ifdef DISPLAY_ARBITER_ROUND_ROBIN_EN
      for (int k = NUM_SRC - 1; k >= 0; k--)
         for (int i = 0; i < NUM_SRC; i++)
            if (bus.req[i] && ((int'(rr_start) + k) % NUM_SRC) == i)
               win_idx = 3'(i);
`else
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (bus.req[i])
            win_idx = 3'(i);
`endif

      take     = 1'b0;
      take_idx = win_idx;
      if (err_hit) begin
         take     = 1'b1;
         take_idx = err_idx;
      end else if (req_any && (state == IDLE ||
                   (state == OPEN && win_idx != owner))) begin
         take = 1'b1;
      end

      grant_nxt = '0;
      for (int i = 0; i < NUM_SRC; i++)
         grant_nxt[i] = take && (3'(i) == take_idx);

      sel_idx   = take ? take_idx : owner;
      sel_req   = 1'b0;
      sel_value = '0;
      sel_hex   = 1'b0;
      sel_err   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (3'(i) == sel_idx) begin
            sel_req   = bus.req[i] && (take || owner_req);
            sel_value = bus.in_value[32*i +: 32];
            sel_hex   = bus.in_hex[i];
            sel_err   = bus.in_error[i];
         end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         count <= '0;
         owner <= '0;
         valid <= 1'b0;
         grant <= '0;
         value <= '0;
         hex   <= 1'b0;
         err   <= 1'b0;
         blank <= 1'b1;
`ifdef DISPLAY_ARBITER_ROUND_ROBIN_EN
         rr_start <= '0;
`endif
      end else begin
         grant <= grant_nxt;
         if (sel_req) begin
            value <= sel_value;
            hex   <= sel_hex;
            err   <= sel_err;
         end
         if (take) begin
            state <= SETTLE;
            count <= SETTLE_LD;
            owner <= take_idx;
            valid <= 1'b1;
            blank <= 1'b1;
`ifdef DISPLAY_ARBITER_ROUND_ROBIN_EN
            rr_start <= 3'((int'(take_idx) + 1) % NUM_SRC);
`endif
         end else begin
            unique case (state)
               IDLE: begin
                  blank <= 1'b1;
               end
               SETTLE: begin
                  if (count == '0) begin
                     state <= HOLD;
                     count <= HOLD_LD;
                     blank <= 1'b0;
                  end else begin
                     count <= count - 1'b1;
                  end
               end
               HOLD: begin
                  if (count == '0)
                     state <= OPEN;
                  else
                     count <= count - 1'b1;
               end
               OPEN: begin
                  if (!req_any) begin
                     state <= IDLE;
                     owner <= '0;
                     valid <= 1'b0;
                     blank <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign bus.value       = value;
   assign bus.show_in_hex = hex;
   assign bus.error       = err;
   assign bus.blank       = blank;
   assign bus.owner       = owner;
   assign bus.owner_valid = valid;
   assign bus.grant       = grant;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: NUM_SRC=3, SETTLE=4, HOLD=8.
module tb_display_arbiter;
   logic clk;
   logic reset_n;
   int   total;
   int   passed;

   display_arbiter_if #(.NUM_SRC(3)) bus ();

   display_arbiter #(
      .NUM_SRC(3),
      .SETTLE_CYCLES(4),
      .HOLD_CYCLES(8)
   ) dut (
      .clock(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_state(input string tag, input logic [2:0] own,
                            input logic vld, input logic blk,
                            input logic [2:0] gnt);
      chk({tag, ".owner"}, 32'(bus.owner), 32'(own));
      chk({tag, ".valid"}, 32'(bus.owner_valid), 32'(vld));
      chk({tag, ".blank"}, 32'(bus.blank), 32'(blk));
      chk({tag, ".grant"}, 32'(bus.grant), 32'(gnt));
   endtask

   initial begin
      total        = 0;
      passed       = 0;
      reset_n      = 1'b0;
      bus.req      = 3'b000;
      bus.in_value = '0;
      bus.in_hex   = 3'b000;
      bus.in_error = 3'b000;
      tick();
      tick();
      chk_state("reset", 3'd0, 1'b0, 1'b1, 3'b000);
      chk("reset.value", bus.value, 32'h0);
      chk("reset.hex", 32'(bus.show_in_hex), 32'h0);
      chk("reset.error", 32'(bus.error), 32'h0);
      reset_n = 1'b1;
      tick();
      chk_state("idle", 3'd0, 1'b0, 1'b1, 3'b000);

      // Source 0 request: grant, 4 blank cycles, then HOLD.
      bus.req = 3'b001;
      bus.in_value[31:0] = 32'h0000007B;
      tick();
      chk_state("t1.grant", 3'd0, 1'b1, 1'b1, 3'b001);
      chk("t1.value", bus.value, 32'h7B);
      for (int k = 0; k < 3; k++) tick();
      chk_state("t1.settle_end", 3'd0, 1'b1, 1'b1, 3'b000);
      tick();
      chk_state("t1.hold", 3'd0, 1'b1, 1'b0, 3'b000);
      chk("t1.hold_value", bus.value, 32'h7B);
      tick();
      tick();

      // Error source 2 preempts source 0 mid-HOLD.
      bus.req = 3'b101;
      bus.in_error = 3'b100;
      bus.in_value[95:64] = 32'h0000DEAD;
      tick();
      chk_state("t3.preempt", 3'd2, 1'b1, 1'b1, 3'b100);
      chk("t3.error", 32'(bus.error), 32'h1);
      chk("t3.value", bus.value, 32'hDEAD);
      bus.req = 3'b100;
      bus.in_error = 3'b000;
      tick();
      chk("t3.error_track", 32'(bus.error), 32'h0);
      chk_state("t3.settle", 3'd2, 1'b1, 1'b1, 3'b000);
      for (int k = 0; k < 3; k++) tick();
      chk_state("t3.hold", 3'd2, 1'b1, 1'b0, 3'b000);

      // Source 1 requests while source 2 is still holding.
      bus.req = 3'b110;
      bus.in_value[63:32] = 32'h12345678;
      bus.in_hex = 3'b010;
      for (int k = 0; k < 7; k++) tick();
      chk_state("t2.hold_last", 3'd2, 1'b1, 1'b0, 3'b000);
      tick();
      chk_state("t2.open", 3'd2, 1'b1, 1'b0, 3'b000);
      tick();
      chk_state("t2.switch", 3'd1, 1'b1, 1'b1, 3'b010);
      chk("t2.value", bus.value, 32'h12345678);
      chk("t2.hex", 32'(bus.show_in_hex), 32'h1);

      // Owner drops req during HOLD; value must stay frozen.
      for (int k = 0; k < 4; k++) tick();
      chk_state("t4.hold", 3'd1, 1'b1, 1'b0, 3'b000);
      bus.req = 3'b000;
      bus.in_value[63:32] = 32'hFFFFFFFF;
      for (int k = 0; k < 3; k++) tick();
      chk("t4.frozen_mid", bus.value, 32'h12345678);
      for (int k = 0; k < 5; k++) tick();
      chk_state("t4.open", 3'd1, 1'b1, 1'b0, 3'b000);
      chk("t4.frozen_open", bus.value, 32'h12345678);
      tick();
      chk_state("t4.idle", 3'd0, 1'b0, 1'b1, 3'b000);
      chk("t4.idle_value", bus.value, 32'h12345678);

      // Reset during SETTLE, then re-grant from IDLE.
      bus.req = 3'b010;
      tick();
      chk_state("t5.grant", 3'd1, 1'b1, 1'b1, 3'b010);
      chk("t5.value", bus.value, 32'hFFFFFFFF);
      tick();
      reset_n = 1'b0;
      tick();
      chk_state("t5.reset", 3'd0, 1'b0, 1'b1, 3'b000);
      chk("t5.reset_value", bus.value, 32'h0);
      chk("t5.reset_hex", 32'(bus.show_in_hex), 32'h0);
      reset_n = 1'b1;
      tick();
      chk_state("t5.regrant", 3'd1, 1'b1, 1'b1, 3'b010);

      // Error owner 1 ignores higher-index error, yields to error 0.
      bus.req = 3'b110;
      bus.in_error = 3'b110;
      tick();
      chk_state("err.keep", 3'd1, 1'b1, 1'b1, 3'b000);
      chk("err.owner_err", 32'(bus.error), 32'h1);
      bus.req = 3'b111;
      bus.in_error = 3'b111;
      bus.in_value[31:0] = 32'h00000BAD;
      tick();
      chk_state("err.lower", 3'd0, 1'b1, 1'b1, 3'b001);
      chk("err.value", bus.value, 32'hBAD);
      tick();
      chk_state("err.stable", 3'd0, 1'b1, 1'b1, 3'b000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit multiplexed display (value / show_in_hex / error inputs of the display driver) among NUM_SRC requesters, e.g. operand entry, result, status.
- Fixed-priority arbitration with a minimum on-screen hold time, so results stay readable.
- A post-switch blanking window covers the display driver's binary-to-BCD reconversion latency.
- Error requests preempt immediately.
- Sits between the calculator core/keypad logic and the display driver.

Parameters:
- NUM_SRC, 3, number of requesters (2..8); index 0 is highest priority.
- SETTLE_CYCLES, 256, cycles blank is held after an ownership change (>=1).
- HOLD_CYCLES, 25000000, minimum cycles an owner keeps the display after settling (>=1; 0.5 s at 50 MHz).

Ports:
- clock  in  1  50 MHz system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_SRC  level request per source.
- in_value  in  32*NUM_SRC  source i value in bits [32*i+31:32*i], two's complement.
- in_hex  in  NUM_SRC  source i wants hex representation.
- in_error  in  NUM_SRC  source i is an error message; only meaningful with req[i]=1.
- value  out  32  value to display driver.
- show_in_hex  out  1  to display driver.
- error  out  1  to display driver.
- blank  out  1  display must show nothing (driver gates segments).
- owner  out  3  index of current owner; 0 when owner_valid=0.
- owner_valid  out  1  a source owns the display.
- grant  out  NUM_SRC  one-hot, 1-cycle pulse when a source gains ownership.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State=IDLE; value=0, show_in_hex=0, error=0, blank=1, owner=0, owner_valid=0, grant=0, counter=0.
  - Reset mid-operation abandons the current owner with no grant or notice.
- All outputs are registered. Display outputs track the owner's inputs with 1-cycle latency while req[owner]=1. They freeze at their last values while req[owner]=0.
- Winner: lowest index i with req[i]=1, computed from the current cycle's inputs.
- IDLE:
  - blank=1, owner_valid=0.
  - If any req is set: grant[winner] pulses next cycle, owner=winner, owner_valid=1, counter=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - blank=1.
  - Counter decrements each cycle. At counter==0: counter=HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - blank=0.
  - Counter decrements each cycle. At counter==0: go to OPEN.
  - A drop of req[owner] does not end HOLD; the frozen value stays displayed.
- OPEN:
  - blank=0.
  - If no req is set: go to IDLE (owner_valid=0, blank=1 next cycle).
  - Else if winner != owner: grant the winner, reload counter=SETTLE_CYCLES-1, go to SETTLE.
  - Else stay in OPEN.
- Error preemption, checked in every state before the normal rules:
  - If some j != owner has req[j] & in_error[j]: the lowest such j is granted immediately and the state goes to SETTLE.
  - If the owner itself is an error source, nobody preempts it except a lower-index error source.
- Simultaneous grant and request drop in the same cycle: the grant still completes; the new owner then holds with a frozen value.
- grant never pulses for the source that already owns the display. At most one grant bit is set per cycle.
- Counter width: $clog2(max(SETTLE_CYCLES, HOLD_CYCLES))+1. No wrap-around is possible because reload always precedes decrement-to-zero.

Optional Feature:
- Macro: DISPLAY_ARBITER_ROUND_ROBIN_EN
- Defined:
  - Non-error arbitration in IDLE/OPEN is round-robin: the search starts at (owner+1) mod NUM_SRC, and at 0 after reset.
  - In OPEN, a different requester wins whenever any other source is requesting, even if the owner still requests.
  - Error preemption remains fixed-priority.
- Undefined: fixed priority exactly as above.

Test Plan:
Test configuration: NUM_SRC=3, SETTLE_CYCLES=4, HOLD_CYCLES=8.
1. Reset, then req=001, in_value0=0x0000007B → grant=001 one cycle after req; blank=1 for 4 cycles; then blank=0, value=0x7B, owner=0, state HOLD for 8 cycles.
2. Source 2 owning and in OPEN, req=110 → grant=010; owner=1 after the grant cycle; blank=1 for 4 cycles. Repeat with source 2 still in HOLD → no switch until the HOLD counter expires.
3. Source 0 owning in HOLD (counter=5), req[2]=1 and in_error[2]=1 → grant=100 next cycle, error=1, SETTLE restarts; HOLD of source 0 is abandoned.
4. Owner drops req during HOLD while in_value changes to 0xFFFFFFFF → value stays frozen at its old value until OPEN; with req=000 in OPEN → IDLE, blank=1, owner_valid=0.
5. reset_n=0 for one cycle while in SETTLE with owner=1 → all outputs at reset values next cycle; req=010 then re-grants source 1 from IDLE.
6. With DISPLAY_ARBITER_ROUND_ROBIN_EN defined, req=111 held steady → owners cycle 0,1,2,0 with one grant per SETTLE+HOLD+1 period.
